// File: rtl/audio_pkg.sv
// Shared audio constants for the PWM playback path and its sample FIFO.
// Level width carries one extra bit so a full FIFO (level == DEPTH) is representable.
package audio_pkg;

  localparam int SAMPLE_W = 8;
  localparam int DEPTH    = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int LEVEL_W = level_width(DEPTH);

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO; head entry visible combinationally, one-cycle write-to-read.
// Writes are dropped while full and reads while empty; simultaneous push/pop keeps count.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH   = SAMPLE_W,
  parameter int ENTRIES = DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [WIDTH-1:0]                wr_data,
  input  logic                            rd_en,
  output logic [WIDTH-1:0]                rd_data,
  output logic                            full,
  output logic                            empty,
  output logic [level_width(ENTRIES)-1:0] count
);

  localparam int ADDR_W = $clog2(ENTRIES);
  localparam int CNT_W  = level_width(ENTRIES);

  logic [WIDTH-1:0]  mem [ENTRIES];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == CNT_W'(ENTRIES));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only pointers and occupancy define FIFO contents.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because ENTRIES is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_pwm_out.sv
// Buffered audio samples played out as PWM; a tick pops one sample, duty updates at period end.
// Producer stalls only on a full FIFO (s_ready = !full); an empty FIFO on a tick plays MIDSCALE.
module sample_pwm_out #(
  parameter int                     SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int                     DEPTH    = audio_pkg::DEPTH,
  parameter logic [SAMPLE_W-1:0]    MIDSCALE = audio_pkg::MIDSCALE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sample_tick,
  input  logic [SAMPLE_W-1:0]       s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      clr_underrun,
  output logic                      pwm_out,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      underrun
);

  logic [SAMPLE_W-1:0] head;
  logic                full;
  logic                empty;
  logic                play_tick;
  logic                pop;
  logic                starve;

  logic [SAMPLE_W-1:0] cur_sample;
  logic [SAMPLE_W-1:0] duty;
  logic [SAMPLE_W-1:0] pwm_cnt;

  assign s_ready   = !full;
  assign play_tick = sample_tick && en;
  assign pop       = play_tick && !empty;
  assign starve    = play_tick && empty;

  sample_fifo #(
    .WIDTH   (SAMPLE_W),
    .ENTRIES (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (level)
  );

  // An empty FIFO is not bypassed by a same-cycle write: silence is played instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sample <= MIDSCALE;
      underrun   <= 1'b0;
    end else begin
      if (pop) begin
        cur_sample <= head;
      end else if (starve) begin
        cur_sample <= MIDSCALE;
      end
      if (starve) begin
        underrun <= 1'b1;
      end else if (clr_underrun) begin
        underrun <= 1'b0;
      end
    end
  end

  // Duty only changes at the wrap so no truncated or stretched pulse is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= MIDSCALE;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= en ? pwm_cnt + 1'b1 : '0;
      if (pwm_cnt == '1) begin
        duty <= cur_sample;
      end
      pwm_out <= en && (pwm_cnt < duty);
    end
  end

endmodule

// File: doc/sample_pwm_out.md
SAMPLE_PWM_OUT -- requirements
Module: sample_pwm_out

Interface
REQ-001 The block SHALL have parameter SAMPLE_W, default 8, giving the sample and PWM resolution in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, giving the sample FIFO depth in entries (power of two).
REQ-003 The block SHALL have parameter MIDSCALE, default 8'h80, giving the silence level used at reset and on underrun.
REQ-004 Port clk, input, 1 bit: system clock; clock clk, all state on its rising edge.
REQ-005 Port rst, input, 1 bit: reset rst, asynchronous, active-high.
REQ-006 Port en, input, 1 bit: playback enable.
REQ-007 Port sample_tick, input, 1 bit: single-cycle sample-rate strobe (one clk every 1500 cycles) from the upstream clock-divider stage.
REQ-008 Port s_data, input, SAMPLE_W bits: unsigned sample from the producer.
REQ-009 Port s_valid, input, 1 bit: s_data is valid.
REQ-010 Port s_ready, output, 1 bit: FIFO can accept a sample.
REQ-011 Port clr_underrun, input, 1 bit: clears the sticky underrun flag.
REQ-012 Port pwm_out, output, 1 bit: registered PWM audio output.
REQ-013 Port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.
REQ-014 Port underrun, output, 1 bit: sticky flag, set when a tick found the FIFO empty.

Function
REQ-015 A write SHALL occur on a clk edge where s_valid && s_ready; s_ready SHALL equal !full, with no dependence on s_valid or sample_tick.
REQ-016 On a sample_tick with en=1 and FIFO non-empty, the head entry SHALL be popped into cur_sample on that edge (1-cycle latency).
REQ-017 On a sample_tick with en=1 and FIFO empty, cur_sample SHALL load MIDSCALE and underrun SHALL set on that edge; there is no write-to-pop bypass.
REQ-018 A simultaneous write and pop SHALL leave level unchanged and SHALL preserve FIFO order.
REQ-019 When full, a pop SHALL be allowed, and the write on that cycle SHALL be blocked because s_ready=0.
REQ-020 sample_tick with en=0 SHALL be ignored (no pop, no underrun); writes SHALL remain enabled.
REQ-021 If clr_underrun and a new underrun event occur on the same cycle, set SHALL win.
REQ-022 pwm_cnt (SAMPLE_W bits) SHALL increment every clk while en=1 and wrap from 2^SAMPLE_W-1 to 0; when en=0 it SHALL be held at 0.
REQ-023 duty SHALL load cur_sample only on the edge where pwm_cnt is at its maximum, giving glitch-free period-boundary updates.
REQ-024 pwm_out SHALL be registered: pwm_out <= en && (pwm_cnt < duty).
REQ-025 duty=0 SHALL give a constantly low output, and duty=255 SHALL give 255 high cycles in each 256-cycle period.
REQ-026 Pointers SHALL wrap modulo DEPTH, and level SHALL range from 0 to DEPTH.

Reset
REQ-027 While rst=1, the FIFO SHALL be emptied (level=0) and s_ready SHALL be 1.
REQ-028 While rst=1, cur_sample and duty SHALL be MIDSCALE, pwm_cnt SHALL be 0, pwm_out SHALL be 0, and underrun SHALL be 0.
REQ-029 A reset mid-playback SHALL discard all queued samples immediately, with no partial PWM period completed.

Structure
REQ-030 SAMPLE_W, DEPTH, MIDSCALE and the level width SHALL be defined in a shared package, audio_pkg.
REQ-031 The FIFO SHALL be a sub-module named sample_fifo (synchronous, single clock, with full, empty and count outputs); the PWM logic and tick handling SHALL be in the top level.

Verification
REQ-032 Scenario: write 0x00, 0x40 and 0xFF, then 3 ticks -> after each next boundary, pwm_out high 0, 64 and 255 cycles per 256-cycle period; underrun=0.
REQ-033 Scenario: write 16 samples, then hold s_valid=1 -> s_ready=0 and level=16; a tick with s_valid high -> level stays 16 after one cycle and order is preserved.
REQ-034 Scenario: tick on an empty FIFO -> cur_sample=0x80 and underrun=1; a later clr_underrun pulse -> underrun=0; clr and an empty tick on the same cycle -> underrun=1.
REQ-035 Scenario: tick with en=0 and level=3 -> level stays 3, pwm_out=0, underrun=0.
REQ-036 Scenario: cur_sample changes mid-period -> the duty change appears only after pwm_cnt passes 255, with no short pulse.
REQ-037 Scenario: assert rst during playback with level=5 -> level=0, pwm_out=0 and s_ready=1 asynchronously; after release, the first tick causes an underrun.
